seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive end of the 8-digit multiplexed 7-segment interface (active-low digit select + active-low segments).
//  Samples the scanned bus, rebuilds all 8 BCD digits, and converts each complete frame back to a binary score.
//  Used for on-board loopback self-check of the score display and for reading back the shown value.
// PARAMETERS
//  STABLE_CYCLES   4        consecutive identical synced samples required before a digit slot is accepted (>=2)
//  TIMEOUT_CYCLES  2000000  clk cycles allowed to collect all 8 digits before the partial frame is discarded
// PORTS
//  clk          in   1   system clock; must be >= 8x STABLE_CYCLES x scan rate
//  rst_n        in   1   asynchronous, active-low reset
//  scan_en      in   1   1 = decode; 0 = hold outputs, clear capture mask and stability counter
//  shift        in   8   digit select, active-low one-hot; bit i low = digit i (0 = least significant)
//  seg          in   7   segments {g,f,e,d,c,b,a}, active-low
//  digits       out  32  last complete frame, digit i in [4i+3:4i]; 4'hF = undecodable
//  score_out    out  32  binary value of last good frame (max 99_999_999), zero-extended
//  score_valid  out  1   one-cycle pulse: score_out updated
//  frame_err    out  1   one-cycle pulse: frame complete but >=1 digit undecodable; score_out unchanged
//  timeout      out  1   one-cycle pulse: partial frame discarded after TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: all outputs 0, digits = 0, mask = 0, FSM = IDLE, counters = 0.
//  Input sync: shift and seg each pass through 2 flops before use. All timing below is relative to synced values.
//  Slot qualification: a slot is valid only if synced shift has exactly one zero bit.
//   - All-ones (blank slot between scans) or multiple zeros: no capture; stability counter cleared.
//  Stability: the counter increments while {shift,seg} equals the previous cycle's value. Any change reloads it to 1.
//   - Capture occurs on the cycle the counter reaches STABLE_CYCLES. At most one capture per slot dwell;
//     re-arm only after the value changes.
//  Capture: seg decodes to BCD. 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010,
//   6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other pattern gives 4'hF.
//   - The decoded value is written to live digit i and sets mask[i]. Re-capturing a digit overwrites it.
//  FSM IDLE -> CONV -> DONE -> IDLE:
//   - IDLE: when mask == 8'hFF, snapshot the live digits, clear mask, set idx = 7 and acc = 0, go to CONV.
//     If any snapshot digit is 4'hF, go to DONE with the err flag set (no arithmetic).
//   - CONV: acc <= acc*10 + snap[idx], then idx--. After idx = 0 has been processed, go to DONE.
//     Exactly 8 cycles. acc is 27 bits; no overflow is possible.
//   - DONE: digits <= snap in every case.
//     - If err: frame_err = 1.
//     - Otherwise: score_out <= acc and score_valid = 1.
//     Then return to IDLE.
//  Latency: let E0 be the edge that captures the 8th digit. score_valid is high for the single cycle
//   following edge E0+10. The err path pulses frame_err after edge E0+2.
//  Captures during CONV/DONE go into the live digits and mask and count toward the next frame.
//   The snapshot is unaffected.
//  Timeout counter:
//   - Cleared when the mask is empty or in the FSM hand-off cycle; otherwise increments each cycle.
//   - At TIMEOUT_CYCLES-1: mask cleared, timeout pulse, counter cleared. Live digits are not cleared.
//  scan_en low: mask, stability counter and timeout counter cleared; an in-flight CONV still completes.
//  Simultaneous events: an FSM hand-off clears the mask in the same cycle as a capture.
//   - If the capture's mask bit would also be set that cycle, the capture wins for that bit; all other bits clear.
//  Reset asserted mid-CONV: immediate return to reset values. No score_valid, frame_err or timeout pulse.
// TESTING
//  1 Scan 12345678, 16-cycle dwell per digit, blank slot between scans -> score_valid=1, score_out=32'd12345678,
//    digits=32'h12345678.
//  2 Scan all zeros -> score_valid pulse, score_out=0. Scan 99999999 -> score_out=32'd99999999.
//  3 Digit 3 seg=7'b1111111, rest valid -> frame_err pulse, digits[15:12]=4'hF, score_out holds previous value.
//  4 shift=8'b1111_1100 for 20 cycles, plus shift changes every 2 cycles with STABLE_CYCLES=4
//    -> no capture, mask stays 0.
//  5 Drive only digits 0..5, then blank for TIMEOUT_CYCLES -> single timeout pulse, mask=0, no score_valid.
//  6 Pull rst_n low 4 cycles after entering CONV -> all outputs 0 immediately, no pulses;
//    a full scan after release -> correct score_valid exactly E0+10.

Source files
------------

// File: rtl/seg_scan_if.sv
// Scanned 7-segment bus (scan_en/shift/seg) plus the decoded frame results.
interface seg_scan_if;
    logic        scan_en;
    logic [7:0]  shift;
    logic [6:0]  seg;
    logic [31:0] digits;
    logic [31:0] score_out;
    logic        score_valid;
    logic        frame_err;
    logic        timeout;

    // No backpressure: score_valid, frame_err and timeout are single-cycle pulses the master must sample.
    modport master (output scan_en, shift, seg,
                    input  digits, score_out, score_valid, frame_err, timeout);
    modport slave  (input  scan_en, shift, seg,
                    output digits, score_out, score_valid, frame_err, timeout);
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of an 8-digit multiplexed 7-segment bus: rebuilds BCD digits per frame
// and converts each complete, decodable frame to a binary score.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus,
    output logic [1:0] dbg_state_o,
    output logic [7:0] dbg_mask_o
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_e;

    logic [7:0]  shift_s1_q, shift_s2_q;
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [14:0] prev_q;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] live_q, live_d, snap_q, snap_d, digits_q, digits_d, score_q, score_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  idx_q, idx_d, slot_idx;
    logic [26:0] acc_q, acc_d;
    logic        err_q, err_d, valid_q, valid_d, ferr_q, ferr_d, tpulse_q, tpulse_d;
    logic        slot_ok, capture, handoff;
    state_e      state_q, state_d;

    function automatic logic [3:0] seg_to_bcd(input logic [6:0] s);
        case (s)
            7'b1000000: seg_to_bcd = 4'd0;
            7'b1111001: seg_to_bcd = 4'd1;
            7'b0100100: seg_to_bcd = 4'd2;
            7'b0110000: seg_to_bcd = 4'd3;
            7'b0011001: seg_to_bcd = 4'd4;
            7'b0010010: seg_to_bcd = 4'd5;
            7'b0000010: seg_to_bcd = 4'd6;
            7'b1111000: seg_to_bcd = 4'd7;
            7'b0000000: seg_to_bcd = 4'd8;
            7'b0010000: seg_to_bcd = 4'd9;
            default:    seg_to_bcd = 4'hF;
        endcase
    endfunction

    function automatic logic has_bad(input logic [31:0] d);
        has_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d[i*4 +: 4] == 4'hF) has_bad = 1'b1;
        end
    endfunction

    assign slot_ok = $onehot(~shift_s2_q);

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!shift_s2_q[i]) slot_idx = 3'(i);
        end
    end

    // Counter saturates at STABLE_CYCLES so a long dwell captures only once.
    always_comb begin
        stab_d  = '0;
        capture = 1'b0;
        if (bus.scan_en && slot_ok) begin
            if ({shift_s2_q, seg_s2_q} == prev_q) begin
                stab_d  = (stab_q == STB_MAX) ? stab_q : stab_q + 1'b1;
                capture = (stab_q == STB_LAST);
            end else begin
                stab_d = SW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        err_d    = err_q;
        digits_d = digits_q;
        score_d  = score_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        tpulse_d = 1'b0;
        live_d   = live_q;
        mask_d   = mask_q;
        tmo_d    = tmo_q;
        handoff  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mask_q == 8'hFF) begin
                    handoff = 1'b1;
                    snap_d  = live_q;
                    idx_d   = 3'd7;
                    acc_d   = '0;
                    err_d   = has_bad(live_q);
                    state_d = err_d ? DONE : CONV;
                end
            end
            CONV: begin
                acc_d = acc_q * 27'd10 + {23'd0, snap_q[{idx_q, 2'b00} +: 4]};
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) state_d = DONE;
            end
            DONE: begin
                digits_d = snap_q;
                if (err_q) begin
                    ferr_d = 1'b1;
                end else begin
                    score_d = {5'd0, acc_q};
                    valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.scan_en) begin
            mask_d = '0;
            tmo_d  = '0;
        end else if (handoff || mask_q == '0) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d    = '0;
            mask_d   = '0;
            tpulse_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        if (handoff) mask_d = '0;

        // Applied last so a same-cycle capture keeps its mask bit across a hand-off.
        if (capture) begin
            live_d[{slot_idx, 2'b00} +: 4] = seg_to_bcd(seg_s2_q);
            mask_d[slot_idx]               = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_s1_q <= 8'hFF;
            shift_s2_q <= 8'hFF;
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
            prev_q     <= 15'h7FFF;
            stab_q     <= '0;
            tmo_q      <= '0;
            live_q     <= '0;
            snap_q     <= '0;
            digits_q   <= '0;
            score_q    <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            tpulse_q   <= 1'b0;
            state_q    <= IDLE;
        end else begin
            shift_s1_q <= bus.shift;
            shift_s2_q <= shift_s1_q;
            seg_s1_q   <= bus.seg;
            seg_s2_q   <= seg_s1_q;
            prev_q     <= {shift_s2_q, seg_s2_q};
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            live_q     <= live_d;
            snap_q     <= snap_d;
            digits_q   <= digits_d;
            score_q    <= score_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            tpulse_q   <= tpulse_d;
            state_q    <= state_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.score_out   = score_q;
    assign bus.score_valid = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.timeout     = tpulse_q;
    assign dbg_state_o     = state_q;
    assign dbg_mask_o      = mask_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built frames and checks score, digits,
// pulse latency, qualification, timeout and mid-conversion reset.
module tb_seg_scan_decoder;
    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic [7:0] dbg_mask;
    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_ferr = 0, n_tmo = 0;
    logic [31:0] exp_q[$];
    logic [31:0] vh, fh;
    int base_valid, base_tmo;

    seg_scan_if bus();

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state),
        .dbg_mask_o (dbg_mask)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.score_valid) n_valid++;
        if (bus.frame_err)   n_ferr++;
        if (bus.timeout)     n_tmo++;
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slot(input logic [7:0] sh, input logic [6:0] sg, input int n);
        bus.shift = sh;
        bus.seg   = sg;
        repeat (n) step();
    endtask

    task automatic drive_digit(input int i, input logic [31:0] bcd, input int n);
        logic [7:0] sh;
        sh = ~(8'h01 << i);
        drive_slot(sh, enc(bcd[i*4 +: 4]), n);
    endtask

    // Digits 0..6 dwell 16 cycles; digit 7 dwells 20 with per-cycle pulse history (bit k = after k edges).
    task automatic scan_frame(input logic [31:0] bcd, output logic [31:0] v, output logic [31:0] f);
        v = '0;
        f = '0;
        for (int i = 0; i < 7; i++) drive_digit(i, bcd, 16);
        bus.shift = 8'h7F;
        bus.seg   = enc(bcd[31:28]);
        for (int k = 1; k <= 20; k++) begin
            step();
            v[k] = bus.score_valid;
            f[k] = bus.frame_err;
        end
        drive_slot(8'hFF, 7'h7F, 8);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.scan_en = 1'b1;
        bus.shift   = 8'hFF;
        bus.seg     = 7'h7F;
        repeat (3) step();
        check("rst_digits", bus.digits, 32'h0);
        check("rst_score", bus.score_out, 32'h0);
        check("rst_pulses", {bus.score_valid, bus.frame_err, bus.timeout}, 32'h0);
        check("rst_state", dbg_state, 32'h0);
        check("rst_mask", dbg_mask, 32'h0);
        rst_n = 1'b1;
        drive_slot(8'hFF, 7'h7F, 4);

        // 1: normal frame
        exp_q.push_back(32'd12345678);
        scan_frame(32'h12345678, vh, fh);
        check("t1_valid_lat", vh, 32'h0001_0000);
        check("t1_score", bus.score_out, exp_q.pop_front());
        check("t1_digits", bus.digits, 32'h12345678);
        check("t1_mask", dbg_mask, 32'h0);

        // 2: boundary values
        exp_q.push_back(32'd0);
        scan_frame(32'h00000000, vh, fh);
        check("t2_zero_lat", vh, 32'h0001_0000);
        check("t2_zero_score", bus.score_out, exp_q.pop_front());
        exp_q.push_back(32'd99999999);
        scan_frame(32'h99999999, vh, fh);
        check("t2_max_lat", vh, 32'h0001_0000);
        check("t2_max_score", bus.score_out, exp_q.pop_front());
        check("t2_max_digits", bus.digits, 32'h99999999);

        // 3: undecodable digit 3
        scan_frame(32'h8765F321, vh, fh);
        check("t3_ferr_lat", fh, 32'h0000_0100);
        check("t3_no_valid", vh, 32'h0);
        check("t3_score_hold", bus.score_out, 32'd99999999);
        check("t3_digits", bus.digits, 32'h8765F321);

        // 4: multi-zero select, then a select changing every 2 cycles
        base_valid = n_valid;
        drive_slot(8'b1111_1100, enc(4'd1), 20);
        check("t4_multi_mask", dbg_mask, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive_slot(8'hFE, enc(4'd1), 2);
            drive_slot(8'hFD, enc(4'd2), 2);
        end
        check("t4_fast_mask", dbg_mask, 32'h0);
        drive_slot(8'hFF, 7'h7F, 8);
        check("t4_no_valid", n_valid, base_valid);

        // 5: partial frame times out
        base_valid = n_valid;
        base_tmo   = n_tmo;
        for (int i = 0; i < 6; i++) drive_digit(i, 32'h00654321, 16);
        check("t5_partial_mask", dbg_mask, 32'h3F);
        drive_slot(8'hFF, 7'h7F, 200);
        check("t5_tmo_count", n_tmo - base_tmo, 32'd1);
        check("t5_mask_clr", dbg_mask, 32'h0);
        check("t5_no_valid", n_valid, base_valid);

        // scan_en low clears the capture mask
        for (int i = 0; i < 3; i++) drive_digit(i, 32'h00000777, 16);
        check("en_mask_set", dbg_mask, 32'h07);
        bus.scan_en = 1'b0;
        step();
        step();
        check("en_mask_clr", dbg_mask, 32'h0);
        drive_slot(8'hFF, 7'h7F, 4);
        bus.scan_en = 1'b1;
        drive_slot(8'hFF, 7'h7F, 4);

        // 6: reset four cycles into CONV, then a clean frame
        base_valid = n_valid;
        base_tmo   = n_tmo;
        for (int i = 0; i < 7; i++) drive_digit(i, 32'h11223344, 16);
        bus.shift = 8'h7F;
        bus.seg   = enc(4'd1);
        repeat (11) step();
        check("t6_in_conv", dbg_state, 32'h1);
        rst_n     = 1'b0;
        bus.shift = 8'hFF;
        bus.seg   = 7'h7F;
        #1;
        check("t6_rst_digits", bus.digits, 32'h0);
        check("t6_rst_score", bus.score_out, 32'h0);
        check("t6_rst_state", dbg_state, 32'h0);
        repeat (4) step();
        check("t6_no_pulses", {n_valid - base_valid, n_tmo - base_tmo}, 32'h0);
        check("t6_rst_outs", {bus.score_valid, bus.frame_err, bus.timeout}, 32'h0);
        rst_n = 1'b1;
        drive_slot(8'hFF, 7'h7F, 4);
        exp_q.push_back(32'd24681357);
        scan_frame(32'h24681357, vh, fh);
        check("t6_valid_lat", vh, 32'h0001_0000);
        check("t6_score", bus.score_out, exp_q.pop_front());
        check("t6_digits", bus.digits, 32'h24681357);
        check("t6_no_ferr", fh, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
